multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle control sequencer for the 16-bit 8-opcode core. It replaces single-cycle decode with an FSM that shares one memory port between fetch and data access, and adds a request/ready memory handshake, a halt state, a memory timeout error and a retired-instruction counter. It sits between the IR/EQ comparator and the datapath muxes (ALU, PC, register file, memory address select).

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps)
MEM_TIMEOUT, 15, max cycles waiting for mem_ready before ERR; 0 disables timeout
TO_W, 4, timeout counter width; must hold MEM_TIMEOUT

Ports:
clk  in  1  core clock
rst_n  in  1  async active-low reset
run  in  1  level; FETCH issues a request only while high
opcode  in  3  IR[15:13]
halt_insn  in  1  decoded halt (jalr with nonzero imm), valid with opcode
EQ  in  1  rA==rB from comparator
mem_ready  in  1  memory accepts/returns this cycle
mem_req  out  1  memory request
MUX_addr  out  1  0:PC 1:ALU result
ir_we  out  1  load IR from mem_rdata
mdr_we  out  1  load MDR from mem_rdata
pc_we  out  1  PC update strobe
FUNC_alu  out  2  00 add, 01 nand, 10 lui-pass
MUX_alu1  out  1  1 for lui
MUX_alu2  out  1  1 = immediate (addi, lw, sw)
MUX_pc  out  2  00 PC+1, 01 PC+1+imm, 10 rB
MUX_rf  out  1  read port 2 = rA (sw, beq), else rC
MUX_tgt  out  2  00 MDR, 01 ALU, 10 PC+1
WE_rf  out  1  register write
WE_dmem  out  1  memory write
halted  out  1  in HALT
err  out  1  in ERR
retired  out  CNT_W  instructions retired

Behaviour:
- State register 3 bits: FETCH, DECODE, EXEC, MEM, WB, HALT, ERR. While rst_n low: state=FETCH, op_q=0, to_cnt=0, retired=0. All outputs 0 during reset.
- All strobes are combinational from state, op_q and inputs. Only state, op_q, to_cnt and retired are registered.
- FETCH: mem_req=run, MUX_addr=0. When run&mem_ready: ir_we=1, go to DECODE. Otherwise stay.
- DECODE: op_q<=opcode. If halt_insn, go to HALT (not retired). Otherwise go to EXEC. No strobes.
- EXEC: FUNC_alu/MUX_alu1/MUX_alu2/MUX_rf driven from op_q in all states after DECODE.
  - add/addi/nand/lui: go to WB.
  - lw/sw: go to MEM.
  - beq: pc_we=1, MUX_pc=EQ?01:00 (EQ sampled this cycle), retire, go to FETCH.
  - jalr: WE_rf=1, MUX_tgt=10, pc_we=1, MUX_pc=10, retire, go to FETCH. Register write and PC write happen in the same edge; old PC+1 is written.
- MEM: mem_req=1, MUX_addr=1, WE_dmem=sw&mem_ready.
  - On mem_ready, lw: mdr_we=1, go to WB.
  - On mem_ready, sw: pc_we=1, MUX_pc=00, retire, go to FETCH.
- WB: WE_rf=1, MUX_tgt = lw?00:01, pc_we=1, MUX_pc=00, retire, go to FETCH.
- Timeout: to_cnt increments each cycle mem_req&!mem_ready, and clears on mem_ready or on leaving FETCH/MEM.
  - If MEM_TIMEOUT!=0 and to_cnt==MEM_TIMEOUT with mem_ready still low, go to ERR.
  - ERR and HALT are sticky; only reset exits. All strobes 0 there. err/halted=1.
- run low in FETCH: no request, to_cnt held at 0. run is ignored in other states, so an in-flight instruction always completes.
- Retire: retired<=retired+1 on each retire strobe, wraps modulo 2^CNT_W.
- CPI: ALU ops 4, beq/jalr 3, sw 4, lw 5, each plus memory wait cycles.
- Async reset mid-MEM drops mem_req and WE_dmem immediately.

Decomposition:
- risc_pkg: opcode constants (ADD..JALR), state encoding, FUNC_alu, MUX_pc and MUX_tgt encodings.
- One sub-module, control_decode: combinational op_q -> FUNC_alu, MUX_alu1, MUX_alu2, MUX_rf and class flags (is_alu, is_mem, is_br, is_jalr).
- FSM, timeout counter and retire counter stay in multicycle_control.

Test Plan:
- Reset then run=1, mem_ready=1, opcode=000 (add): ir_we at cycle 0, WE_rf&MUX_tgt=01&pc_we at cycle 3, retired=1 after 4 cycles.
- lw with mem_ready delayed 2 cycles in MEM: mdr_we once, WE_rf with MUX_tgt=00 the cycle after, retired increments once, WE_dmem never asserted.
- beq with EQ=1 then EQ=0: MUX_pc=01 then 00 in EXEC, pc_we single pulse each, WE_rf=0, 3 cycles each.
- MEM_TIMEOUT=3, mem_ready held 0 in FETCH: err=1 after cycle 4, all strobes 0; further mem_ready has no effect until rst_n pulse.
- halt_insn=1 at DECODE: halted=1 next cycle, retired unchanged, mem_req stays 0. Also check retired wraps 0xFFFF->0 with CNT_W=16 preloaded by running 65536 adds (or CNT_W=4, 16 adds).

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle control sequencer of the 16-bit core.
package multicycle_control_pkg;

  // Opcode field IR[15:13]
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  // ALU function select
  localparam logic [1:0] FUNC_ADD  = 2'b00;
  localparam logic [1:0] FUNC_NAND = 2'b01;
  localparam logic [1:0] FUNC_LUI  = 2'b10;

  // PC source select
  localparam logic [1:0] PC_INC = 2'b00;  // PC+1
  localparam logic [1:0] PC_BR  = 2'b01;  // PC+1+imm
  localparam logic [1:0] PC_RB  = 2'b10;  // rB

  // Register-file write data select
  localparam logic [1:0] TGT_MDR = 2'b00;
  localparam logic [1:0] TGT_ALU = 2'b01;
  localparam logic [1:0] TGT_PC1 = 2'b10;

  // Static per-opcode datapath controls plus instruction class
  typedef struct packed {
    logic [1:0] func_alu;
    logic       mux_alu1;
    logic       mux_alu2;
    logic       mux_rf;
    logic       is_alu;
    logic       is_mem;
    logic       is_br;
    logic       is_jalr;
  } dec_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> core signal bundle. master = sequencer, slave = datapath/memory side.
interface multicycle_control_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [2:0]       opcode;
  logic             halt_insn;
  logic             EQ;
  logic             mem_ready;
  logic             mem_req;
  logic             MUX_addr;
  logic             ir_we;
  logic             mdr_we;
  logic             pc_we;
  logic [1:0]       FUNC_alu;
  logic             MUX_alu1;
  logic             MUX_alu2;
  logic [1:0]       MUX_pc;
  logic             MUX_rf;
  logic [1:0]       MUX_tgt;
  logic             WE_rf;
  logic             WE_dmem;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, opcode, halt_insn, EQ, mem_ready,
    output mem_req, MUX_addr, ir_we, mdr_we, pc_we, FUNC_alu, MUX_alu1,
           MUX_alu2, MUX_pc, MUX_rf, MUX_tgt, WE_rf, WE_dmem, halted, err,
           retired
  );

  modport slave (
    output run, opcode, halt_insn, EQ, mem_ready,
    input  mem_req, MUX_addr, ir_we, mdr_we, pc_we, FUNC_alu, MUX_alu1,
           MUX_alu2, MUX_pc, MUX_rf, MUX_tgt, WE_rf, WE_dmem, halted, err,
           retired
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// Pure opcode decode: static datapath selects and instruction class flags.
module control_decode
  import multicycle_control_pkg::*;
(
  input  logic [2:0] op_i,
  output dec_t       dec_o
);

  // Opcode -> ALU/operand selects and class; beq/jalr leave the ALU at add
  always_comb begin
    dec_o = '0;
    case (op_i)
      OP_ADD:  dec_o.is_alu = 1'b1;
      OP_ADDI: begin dec_o.is_alu = 1'b1; dec_o.mux_alu2 = 1'b1; end
      OP_NAND: begin dec_o.is_alu = 1'b1; dec_o.func_alu = FUNC_NAND; end
      OP_LUI:  begin
        dec_o.is_alu   = 1'b1;
        dec_o.func_alu = FUNC_LUI;
        dec_o.mux_alu1 = 1'b1;
      end
      OP_SW:   begin dec_o.is_mem = 1'b1; dec_o.mux_alu2 = 1'b1; dec_o.mux_rf = 1'b1; end
      OP_LW:   begin dec_o.is_mem = 1'b1; dec_o.mux_alu2 = 1'b1; end
      OP_BEQ:  begin dec_o.is_br  = 1'b1; dec_o.mux_rf = 1'b1; end
      OP_JALR: dec_o.is_jalr = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: shared-port fetch/data access, ready handshake,
// halt, memory timeout error and retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

  localparam bit             TO_EN  = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             to_hit;
  dec_t             dec;

  logic       mem_req, mux_addr, ir_we, mdr_we, pc_we;
  logic       mux_alu1, mux_alu2, mux_rf, we_rf, we_dmem, halted, err;
  logic [1:0] func_alu, mux_pc, mux_tgt;

  control_decode u_dec (
    .op_i  (op_q),
    .dec_o (dec)
  );

  // Wait budget exhausted while the memory is still not ready
  assign to_hit = TO_EN && (to_cnt_q == TO_MAX) && !bus.mem_ready;

  // Next state and strobes; everything forced low while reset is asserted
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    retire   = 1'b0;
    mem_req  = 1'b0;
    mux_addr = 1'b0;
    ir_we    = 1'b0;
    mdr_we   = 1'b0;
    pc_we    = 1'b0;
    func_alu = FUNC_ADD;
    mux_alu1 = 1'b0;
    mux_alu2 = 1'b0;
    mux_rf   = 1'b0;
    mux_pc   = PC_INC;
    mux_tgt  = TGT_MDR;
    we_rf    = 1'b0;
    we_dmem  = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;
    if (rst_n) begin
      // Static operand selects are valid from EXEC until the instruction retires
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        func_alu = dec.func_alu;
        mux_alu1 = dec.mux_alu1;
        mux_alu2 = dec.mux_alu2;
        mux_rf   = dec.mux_rf;
      end
      case (state_q)
        S_FETCH: begin
          mem_req = bus.run;
          if (bus.run && bus.mem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else if (bus.run && to_hit) begin
            state_d = S_ERR;
          end
        end
        S_DECODE: begin
          op_d    = bus.opcode;
          state_d = bus.halt_insn ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          if (dec.is_alu) begin
            state_d = S_WB;
          end else if (dec.is_mem) begin
            state_d = S_MEM;
          end else if (dec.is_br) begin
            pc_we   = 1'b1;
            mux_pc  = bus.EQ ? PC_BR : PC_INC;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else if (dec.is_jalr) begin
            // Link register gets the old PC+1 on the same edge the PC moves
            we_rf   = 1'b1;
            mux_tgt = TGT_PC1;
            pc_we   = 1'b1;
            mux_pc  = PC_RB;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mux_addr = 1'b1;
          we_dmem  = (op_q == OP_SW) && bus.mem_ready;
          if (bus.mem_ready) begin
            if (op_q == OP_LW) begin
              mdr_we  = 1'b1;
              state_d = S_WB;
            end else begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
          end else if (to_hit) begin
            state_d = S_ERR;
          end
        end
        S_WB: begin
          we_rf   = 1'b1;
          mux_tgt = (op_q == OP_LW) ? TGT_MDR : TGT_ALU;
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        S_HALT:  halted = 1'b1;
        S_ERR:   err    = 1'b1;
        default: state_d = S_ERR;
      endcase
    end
  end

  // Timeout counter counts unanswered request cycles; clears otherwise
  always_comb begin
    to_cnt_d = '0;
    if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q &&
        mem_req && !bus.mem_ready)
      to_cnt_d = to_cnt_q + TO_W'(1);
  end

  // State, latched opcode, timeout and retire counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      to_cnt_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      to_cnt_q <= to_cnt_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.mem_req  = mem_req;
  assign bus.MUX_addr = mux_addr;
  assign bus.ir_we    = ir_we;
  assign bus.mdr_we   = mdr_we;
  assign bus.pc_we    = pc_we;
  assign bus.FUNC_alu = func_alu;
  assign bus.MUX_alu1 = mux_alu1;
  assign bus.MUX_alu2 = mux_alu2;
  assign bus.MUX_pc   = mux_pc;
  assign bus.MUX_rf   = mux_rf;
  assign bus.MUX_tgt  = mux_tgt;
  assign bus.WE_rf    = we_rf;
  assign bus.WE_dmem  = we_dmem;
  assign bus.halted   = halted;
  assign bus.err      = err;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (CNT_W=4 for wrap, MEM_TIMEOUT=3).
module tb_multicycle_control;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  multicycle_control_if #(.CNT_W(4)) bus ();

  multicycle_control #(.CNT_W(4), .MEM_TIMEOUT(3), .TO_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl: mem_req MUX_addr ir_we mdr_we pc_we WE_rf WE_dmem halted err
  // dp : FUNC_alu[1:0] MUX_alu1 MUX_alu2 MUX_rf MUX_pc[1:0] MUX_tgt[1:0]
  logic [8:0] ctl_w, dp_w;
  assign ctl_w = {bus.mem_req, bus.MUX_addr, bus.ir_we, bus.mdr_we, bus.pc_we,
                  bus.WE_rf, bus.WE_dmem, bus.halted, bus.err};
  assign dp_w  = {bus.FUNC_alu, bus.MUX_alu1, bus.MUX_alu2, bus.MUX_rf,
                  bus.MUX_pc, bus.MUX_tgt};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check strobes one step away from the edge, then advance one clock
  task automatic cyc(input string tag, input logic [8:0] ec, input logic [8:0] ed);
    #1;
    chk({tag, "_ctl"}, {7'd0, ctl_w}, {7'd0, ec});
    chk({tag, "_dp"},  {7'd0, dp_w},  {7'd0, ed});
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.run = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 3'd0;
    bus.halt_insn = 1'b0; bus.EQ = 1'b0;
    #1;
    chk("rst_ctl", {7'd0, ctl_w}, 16'h0);
    chk("rst_dp",  {7'd0, dp_w},  16'h0);
    chk("rst_ret", {12'd0, bus.retired}, 16'd0);
    tick(); tick();
    rst_n = 1'b1;

    // add: 4 cycles
    bus.opcode = 3'b000;
    cyc("add_f", 9'b101000000, 9'b000000000);
    cyc("add_d", 9'b000000000, 9'b000000000);
    cyc("add_e", 9'b000000000, 9'b000000000);
    cyc("add_w", 9'b000011000, 9'b000000001);
    chk("add_ret", {12'd0, bus.retired}, 16'd1);

    // lw with two wait cycles in MEM
    bus.opcode = 3'b101;
    cyc("lw_f",  9'b101000000, 9'b000000000);
    cyc("lw_d",  9'b000000000, 9'b000000000);
    cyc("lw_e",  9'b000000000, 9'b000100000);
    bus.mem_ready = 1'b0;
    cyc("lw_m0", 9'b110000000, 9'b000100000);
    cyc("lw_m1", 9'b110000000, 9'b000100000);
    chk("lw_ret_mid", {12'd0, bus.retired}, 16'd1);
    bus.mem_ready = 1'b1;
    cyc("lw_m2", 9'b110100000, 9'b000100000);
    cyc("lw_w",  9'b000011000, 9'b000100000);
    chk("lw_ret", {12'd0, bus.retired}, 16'd2);

    // sw: write and retire from MEM
    bus.opcode = 3'b100;
    cyc("sw_f", 9'b101000000, 9'b000000000);
    cyc("sw_d", 9'b000000000, 9'b000000000);
    cyc("sw_e", 9'b000000000, 9'b000110000);
    cyc("sw_m", 9'b110010100, 9'b000110000);
    chk("sw_ret", {12'd0, bus.retired}, 16'd3);

    // beq taken then not taken
    bus.opcode = 3'b110; bus.EQ = 1'b1;
    cyc("beq1_f", 9'b101000000, 9'b000000000);
    cyc("beq1_d", 9'b000000000, 9'b000000000);
    cyc("beq1_e", 9'b000010000, 9'b000010100);
    chk("beq1_ret", {12'd0, bus.retired}, 16'd4);
    bus.EQ = 1'b0;
    cyc("beq0_f", 9'b101000000, 9'b000000000);
    cyc("beq0_d", 9'b000000000, 9'b000000000);
    cyc("beq0_e", 9'b000010000, 9'b000010000);
    chk("beq0_ret", {12'd0, bus.retired}, 16'd5);

    // jalr: link write and PC<-rB together
    bus.opcode = 3'b111;
    cyc("jalr_f", 9'b101000000, 9'b000000000);
    cyc("jalr_d", 9'b000000000, 9'b000000000);
    cyc("jalr_e", 9'b000011000, 9'b000001010);
    chk("jalr_ret", {12'd0, bus.retired}, 16'd6);

    // addi / nand / lui operand selects
    bus.opcode = 3'b001;
    cyc("addi_f", 9'b101000000, 9'b000000000);
    cyc("addi_d", 9'b000000000, 9'b000000000);
    cyc("addi_e", 9'b000000000, 9'b000100000);
    cyc("addi_w", 9'b000011000, 9'b000100001);
    bus.opcode = 3'b010;
    cyc("nand_f", 9'b101000000, 9'b000000000);
    cyc("nand_d", 9'b000000000, 9'b000000000);
    cyc("nand_e", 9'b000000000, 9'b010000000);
    cyc("nand_w", 9'b000011000, 9'b010000001);
    bus.opcode = 3'b011;
    cyc("lui_f", 9'b101000000, 9'b000000000);
    cyc("lui_d", 9'b000000000, 9'b000000000);
    cyc("lui_e", 9'b000000000, 9'b101000000);
    cyc("lui_w", 9'b000011000, 9'b101000001);
    chk("alu_ret", {12'd0, bus.retired}, 16'd9);

    // 4-bit counter wrap: 9 + 6 = 15, one more -> 0
    bus.opcode = 3'b000;
    for (int i = 0; i < 6; i++) begin
      tick(); tick(); tick(); tick();
    end
    chk("ret_15", {12'd0, bus.retired}, 16'd15);
    tick(); tick(); tick(); tick();
    chk("ret_wrap", {12'd0, bus.retired}, 16'd0);

    // run low: no request and no timeout even with memory idle
    bus.run = 1'b0; bus.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc("idle", 9'b000000000, 9'b000000000);
    bus.mem_ready = 1'b1;
    cyc("idle_rdy", 9'b000000000, 9'b000000000);
    bus.run = 1'b1;

    // halt at DECODE: sticky, not retired
    bus.opcode = 3'b111; bus.halt_insn = 1'b1;
    cyc("halt_f", 9'b101000000, 9'b000000000);
    cyc("halt_d", 9'b000000000, 9'b000000000);
    cyc("halt_h0", 9'b000000010, 9'b000000000);
    cyc("halt_h1", 9'b000000010, 9'b000000000);
    chk("halt_ret", {12'd0, bus.retired}, 16'd0);

    // async reset mid-MEM drops request immediately
    rst_n = 1'b0; #2; rst_n = 1'b1;
    bus.halt_insn = 1'b0; bus.opcode = 3'b100;
    cyc("rr_f", 9'b101000000, 9'b000000000);
    cyc("rr_d", 9'b000000000, 9'b000000000);
    cyc("rr_e", 9'b000000000, 9'b000110000);
    bus.mem_ready = 1'b0;
    #1;
    chk("rr_mem", {7'd0, ctl_w}, {7'd0, 9'b110000000});
    rst_n = 1'b0;
    #1;
    chk("rr_async", {7'd0, ctl_w}, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // timeout in FETCH: 4 unanswered cycles then ERR
    cyc("to_0", 9'b100000000, 9'b000000000);
    cyc("to_1", 9'b100000000, 9'b000000000);
    cyc("to_2", 9'b100000000, 9'b000000000);
    cyc("to_3", 9'b100000000, 9'b000000000);
    cyc("to_err", 9'b000000001, 9'b000000000);
    bus.mem_ready = 1'b1;
    cyc("err_s0", 9'b000000001, 9'b000000000);
    cyc("err_s1", 9'b000000001, 9'b000000000);
    chk("err_ret", {12'd0, bus.retired}, 16'd0);
    rst_n = 1'b0; #2; rst_n = 1'b1;
    cyc("err_clr", 9'b101000000, 9'b000000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
